// File: rtl/alu_result_stage.sv
// sync_fifo: small generic in-order FIFO with synchronous clear.
// Latency: a push into an empty FIFO is visible at the head after one edge.
// Backpressure: the caller gates push with cnt; a pop when empty must not be issued.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          push,
   input  logic [W-1:0]  push_dat,
   input  logic          pop,
   output logic [W-1:0]  head_dat,
   output logic [CW-1:0] cnt
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign head_dat = mem[rd_ptr];

   // Pointer wrap that stays correct for non-power-of-two depths.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Storage, pointers and occupancy; clear wins over push and pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

endmodule

// alu_result_stage: condition check, NZCV update and 2-entry result buffer behind the ALU.
// Latency: 1 cycle from accept to wb head (empty buffer) and to flags/c_flag.
// Backpressure: in_ready = buffer not full and no flush; independent of wb_ready.
module alu_result_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        alu_op,
   input  logic [3:0]        cond,
   input  logic              s_bit,
   input  logic [REG_AW-1:0] rd,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [3:0]        nzcv_in,
   input  logic              flush,
   output logic              c_flag,
   output logic [3:0]        flags,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [REG_AW-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic [CNT_W-1:0]  fail_cnt
);

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   wb_entry_t  push_dat;
   wb_entry_t  head_dat;
   logic [1:0] cnt;
   logic       acc;
   logic       pass;
   logic       is_cmp;
   logic       is_arith;
   logic       flag_upd;
   logic       push_vld;
   logic       pop_vld;
   logic       fl_n, fl_z, fl_c, fl_v;

   assign fl_n = flags[3];
   assign fl_z = flags[2];
   assign fl_c = flags[1];
   assign fl_v = flags[0];

   assign in_ready = (cnt < 2'd2) & ~flush;
   assign acc      = in_valid & in_ready;
   assign is_cmp   = (alu_op[3:2] == 2'b10);
   assign is_arith = ((alu_op >= 4'd2) && (alu_op <= 4'd7)) || (alu_op == 4'd10) || (alu_op == 4'd11);
   assign flag_upd = acc & pass & (s_bit | is_cmp);
   assign push_vld = acc & pass & ~is_cmp;
   assign wb_valid = (cnt != 2'd0);
   assign pop_vld  = wb_valid & wb_ready & ~flush;
   assign c_flag   = fl_c;
   assign wb_rd    = head_dat.rd;
   assign wb_data  = head_dat.data;

   assign push_dat.rd   = rd;
   assign push_dat.data = alu_out;

   // Condition code evaluated against the architected (registered) flags.
   always_comb begin
      pass = 1'b0;
      case (cond)
         4'd0:    pass = fl_z;
         4'd1:    pass = ~fl_z;
         4'd2:    pass = fl_c;
         4'd3:    pass = ~fl_c;
         4'd4:    pass = fl_n;
         4'd5:    pass = ~fl_n;
         4'd6:    pass = fl_v;
         4'd7:    pass = ~fl_v;
         4'd8:    pass = fl_c & ~fl_z;
         4'd9:    pass = ~fl_c | fl_z;
         4'd10:   pass = (fl_n == fl_v);
         4'd11:   pass = (fl_n != fl_v);
         4'd12:   pass = ~fl_z & (fl_n == fl_v);
         4'd13:   pass = fl_z | (fl_n != fl_v);
         4'd14:   pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

   // NZCV register: N,Z always follow the ALU; C,V only for arithmetic ops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= 4'b0000;
      end else if (flag_upd) begin
         flags[3:2] <= nzcv_in[3:2];
         if (is_arith) flags[1:0] <= nzcv_in[1:0];
      end
   end

   // Saturating count of instructions consumed with a failed condition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail_cnt <= '0;
      end else if (acc && !pass && (fail_cnt != {CNT_W{1'b1}})) begin
         fail_cnt <= fail_cnt + 1'b1;
      end
   end

   sync_fifo #(
      .W     ($bits(wb_entry_t)),
      .DEPTH (2)
   ) u_wb_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (flush),
      .push     (push_vld),
      .push_dat (push_dat),
      .pop      (pop_vld),
      .head_dat (head_dat),
      .cnt      (cnt)
   );

endmodule
